alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor of the team's 32-bit add/sub ALU.
- Adds logic ops, signed/unsigned compare, and an iterative multi-cycle shifter (one bit per cycle) behind a valid/ready interface. Results and flags are registered.
- Sits between the operand source (register file or testbench driver) and the result consumer in the lab datapath experiments.

Parameters:
WIDTH, 32, operand/result width in bits; power of two, >= 8
OPW, 4, opcode width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operation request valid
in_ready  out  1  block can accept a request
op  in  OPW  opcode, sampled on accept
a  in  WIDTH  operand A (two's complement)
b  in  WIDTH  operand B (two's complement); shift ops use b[$clog2(WIDTH)-1:0] as shift amount
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  operation result
carry  out  1  carry-out (ADD/SUB only)
zero  out  1  result == 0
overflow  out  1  signed overflow (ADD/SUB), MUL high-half nonzero when enabled
negative  out  1  result[WIDTH-1]
illegal  out  1  opcode not supported

Behaviour:
- Reset (rst_n low, async): state=IDLE. out_valid=0. result=0. carry=zero=overflow=negative=illegal=0. in_ready=1 after release. Reset mid-operation aborts the op; no output is produced.
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, MUL=10 (optional feature). All other codes are illegal.
- FSM states: IDLE, SHIFT, MUL, DONE.
- in_ready = (state==IDLE). Accept = in_valid & in_ready; op, a and b are captured on accept.
- IDLE, accept of a single-cycle op (ADD..SLTU, or illegal) -> DONE. Result and flags are registered that edge, so out_valid rises 1 cycle after accept.
- IDLE, accept of a shift op:
  - shamt==0 -> DONE with result=a.
  - otherwise -> SHIFT with cnt=shamt.
- SHIFT: each cycle shift the working register by 1 (SLL zero-fill; SRL zero-fill; SRA msb-fill) and decrement cnt. When cnt reaches 1, the final shift is performed and the FSM goes to DONE. Latency = shamt+1 cycles to out_valid.
- DONE: out_valid=1; outputs are held stable while out_ready=0. When out_ready=1 -> IDLE, out_valid=0 the next cycle. No new request is accepted in the same cycle (no overlap).
- ADD:
  - {carry,result} = a + b.
  - overflow = (a[msb]==b[msb]) & (result[msb]!=a[msb]).
- SUB:
  - b' = ~b + 1, computed at WIDTH+1 bits.
  - {carry,result} = a + ~b + 1, so carry=1 means no borrow.
  - overflow = (a[msb]!=b[msb]) & (result[msb]!=a[msb]). This is correct for b = most-negative.
- AND/OR/XOR: bitwise; carry=overflow=0.
- SLT: result = signed(a)<signed(b) ? 1 : 0. SLTU: unsigned compare, same result encoding. carry=overflow=0 for both.
- Shifts: carry=overflow=0.
- zero and negative are derived from the final result for every op.
- Illegal op: result=0, zero=1, illegal=1, other flags 0; latency 1.
- Width rule: internal adder is WIDTH+1 bits; no truncation before the carry is extracted.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - op=10 is MUL: unsigned shift-add, one partial product per cycle, WIDTH cycles in state MUL.
  - Latency WIDTH+1 to out_valid.
  - result = low WIDTH bits of the product; overflow = (high WIDTH bits != 0); carry=0.
- Undefined: MUL state and multiplier datapath are absent; op=10 is treated as illegal.

Decomposition:
- Package alu_seq_pkg: opcode localparams/enum (ALU_ADD..ALU_MUL), FSM state enum, shamt width function.
- Sub-module alu_addsub_flags: combinational WIDTH-parametrised add/sub producing result, carry, overflow. The FSM, shifter and multiplier stay in alu_seq.

Test Plan:
1. ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, carry=0, negative=1, zero=0; out_valid 1 cycle after accept.
2. SUB a=5, b=5 -> result 0, zero=1, carry=1, overflow=0. SUB a=0, b=1 -> result 0xFFFFFFFF, carry=0.
3. SRA a=0x80000000, b=31 -> result 0xFFFFFFFF, out_valid 32 cycles after accept. SLL shamt=0 -> result=a, latency 1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, second request ignored until release.
5. Assert rst_n low during SHIFT (shamt=20, cycle 10) -> out_valid=0, in_ready=1 after release, no stale result.
6. op=11 -> illegal=1, zero=1, result=0. With ALU_SEQ_MUL_EN: MUL 0x10000*0x10000 -> result 0, overflow=1, zero=1, latency 33.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the alu_seq datapath.
// The ALU_SEQ_MUL_EN macro adds the MUL state to the encoding.
package alu_seq_pkg;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLT  = 5;
    localparam int ALU_SLTU = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_MUL  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
        ST_MUL   = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_t;

    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_addsub_flags.sv
// Combinational add/subtract on a WIDTH+1 bit adder; carry is taken before truncation.
// For subtract, carry=1 means no borrow.
module alu_addsub_flags #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_full;

    assign w_b    = i_sub ? ~i_b : i_b;
    assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
    assign o_sum  = w_full[WIDTH-1:0];
    assign o_carry = w_full[WIDTH];
    // Comparing against the inverted operand covers both ADD and SUB, including b = most-negative.
    assign o_overflow = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (w_full[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic/compare, one-bit-per-cycle shifter,
// and an optional shift-add multiplier enabled by the ALU_SEQ_MUL_EN macro.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    output logic             illegal,
    output state_t           o_dbg_state
);

    localparam int SHW   = shamt_w(WIDTH);
    localparam int CNT_W = SHW + 1;

    // Handshake: a request transfers on a rising edge with in_valid & in_ready
    // (in_ready only in IDLE); a result transfers with out_valid & out_ready
    // (out_valid only in DONE) and outputs stay frozen until then.

    state_t            r_state, w_state_nxt;
    logic [OPW-1:0]    r_op, w_op_nxt;
    logic [WIDTH-1:0]  r_result, w_result_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_carry, w_carry_nxt;
    logic              r_zero, w_zero_nxt;
    logic              r_overflow, w_overflow_nxt;
    logic              r_negative, w_negative_nxt;
    logic              r_illegal, w_illegal_nxt;
    logic [WIDTH-1:0]  w_as_sum;
    logic              w_as_carry, w_as_ovf;
    logic [SHW-1:0]    w_shamt;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]  r_mul_hi, w_mul_hi_nxt;
    logic [WIDTH-1:0]  r_mcand, w_mcand_nxt;
    logic [WIDTH:0]    w_mul_sum;
`endif

    alu_addsub_flags #(.WIDTH(WIDTH)) u_addsub (
        .i_a        (a),
        .i_b        (b),
        .i_sub      (op == OPW'(ALU_SUB)),
        .o_sum      (w_as_sum),
        .o_carry    (w_as_carry),
        .o_overflow (w_as_ovf)
    );

    assign w_shamt = b[SHW-1:0];
`ifdef ALU_SEQ_MUL_EN
    // Partial-product step: product is {r_mul_hi, r_result}, multiplier bits leave from the bottom.
    assign w_mul_sum = {1'b0, r_mul_hi} + (r_result[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_result_nxt   = r_result;
        w_cnt_nxt      = r_cnt;
        w_carry_nxt    = r_carry;
        w_zero_nxt     = r_zero;
        w_overflow_nxt = r_overflow;
        w_negative_nxt = r_negative;
        w_illegal_nxt  = r_illegal;
`ifdef ALU_SEQ_MUL_EN
        w_mul_hi_nxt   = r_mul_hi;
        w_mcand_nxt    = r_mcand;
`endif
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_op_nxt       = op;
                    w_carry_nxt    = 1'b0;
                    w_overflow_nxt = 1'b0;
                    w_illegal_nxt  = 1'b0;
                    w_state_nxt    = ST_DONE;
                    case (op)
                        OPW'(ALU_ADD), OPW'(ALU_SUB): begin
                            w_result_nxt   = w_as_sum;
                            w_carry_nxt    = w_as_carry;
                            w_overflow_nxt = w_as_ovf;
                        end
                        OPW'(ALU_AND):  w_result_nxt = a & b;
                        OPW'(ALU_OR):   w_result_nxt = a | b;
                        OPW'(ALU_XOR):  w_result_nxt = a ^ b;
                        OPW'(ALU_SLT):  w_result_nxt = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                        OPW'(ALU_SLTU): w_result_nxt = {{(WIDTH-1){1'b0}}, a < b};
                        OPW'(ALU_SLL), OPW'(ALU_SRL), OPW'(ALU_SRA): begin
                            w_result_nxt = a;
                            w_cnt_nxt    = {1'b0, w_shamt};
                            if (w_shamt != '0) w_state_nxt = ST_SHIFT;
                        end
`ifdef ALU_SEQ_MUL_EN
                        OPW'(ALU_MUL): begin
                            w_result_nxt = b;
                            w_mcand_nxt  = a;
                            w_mul_hi_nxt = '0;
                            w_cnt_nxt    = CNT_W'(WIDTH);
                            w_state_nxt  = ST_MUL;
                        end
`endif
                        default: begin
                            w_result_nxt  = '0;
                            w_illegal_nxt = 1'b1;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                case (r_op)
                    OPW'(ALU_SLL): w_result_nxt = {r_result[WIDTH-2:0], 1'b0};
                    OPW'(ALU_SRL): w_result_nxt = {1'b0, r_result[WIDTH-1:1]};
                    default:       w_result_nxt = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
                endcase
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                w_mul_hi_nxt = w_mul_sum[WIDTH:1];
                w_result_nxt = {w_mul_sum[0], r_result[WIDTH-1:1]};
                w_cnt_nxt    = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_overflow_nxt = (w_mul_sum[WIDTH:1] != '0);
                    w_state_nxt    = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // zero/negative always describe the final result, so they are set on entry to DONE.
        if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
            w_zero_nxt     = (w_result_nxt == '0);
            w_negative_nxt = w_result_nxt[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_negative <= 1'b0;
            r_illegal  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_mul_hi   <= '0;
            r_mcand    <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_result   <= w_result_nxt;
            r_cnt      <= w_cnt_nxt;
            r_carry    <= w_carry_nxt;
            r_zero     <= w_zero_nxt;
            r_overflow <= w_overflow_nxt;
            r_negative <= w_negative_nxt;
            r_illegal  <= w_illegal_nxt;
`ifdef ALU_SEQ_MUL_EN
            r_mul_hi   <= w_mul_hi_nxt;
            r_mcand    <= w_mcand_nxt;
`endif
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign result      = r_result;
    assign carry       = r_carry;
    assign zero        = r_zero;
    assign overflow    = r_overflow;
    assign negative    = r_negative;
    assign illegal     = r_illegal;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32); MUL vectors run when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry, zero, overflow, negative, illegal;
    state_t      dbg_state;

    int n_vec;
    int n_err;
    logic [31:0] exp_q[$];

    alu_seq #(.WIDTH(32), .OPW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .carry       (carry),
        .zero        (zero),
        .overflow    (overflow),
        .negative    (negative),
        .illegal     (illegal),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // flags packed as {carry, zero, overflow, negative, illegal}
    task automatic run_op(input string tag, input logic [3:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b, input int exp_lat, input logic [31:0] exp_res,
                          input logic [4:0] exp_flags);
        int lat;
        logic [31:0] e;
        exp_q.push_back(exp_res);
        @(negedge clk);
        chk({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; op = t_op; a = t_a; b = t_b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        e = exp_q.pop_front();
        chk({tag, "/result"}, result, e);
        chk({tag, "/flags"}, {27'd0, carry, zero, overflow, negative, illegal}, {27'd0, exp_flags});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/drain"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset/outs", {result[15:0], 9'd0, out_valid, carry, zero, overflow, negative, illegal, 1'b0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset/in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset/out_valid", {31'd0, out_valid}, 32'd0);

        run_op("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'd1,          1, 32'h8000_0000, 5'b00110);
        run_op("add_carry",4'd0, 32'hFFFF_FFFF, 32'd1,          1, 32'h0000_0000, 5'b11000);
        run_op("sub_eq",   4'd1, 32'd5,         32'd5,          1, 32'h0000_0000, 5'b11000);
        run_op("sub_borrow",4'd1,32'd0,         32'd1,          1, 32'hFFFF_FFFF, 5'b00010);
        run_op("sub_minneg",4'd1,32'd0,         32'h8000_0000,  1, 32'h8000_0000, 5'b00110);
        run_op("and",      4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0,  1, 32'h00F0_00F0, 5'b00000);
        run_op("or",       4'd3, 32'h0F0F_0000, 32'h0000_00F0,  1, 32'h0F0F_00F0, 5'b00000);
        run_op("xor",      4'd4, 32'hFFFF_0000, 32'hFFFF_FFFF,  1, 32'h0000_FFFF, 5'b00000);
        run_op("slt",      4'd5, 32'hFFFF_FFFF, 32'd1,          1, 32'd1,         5'b00000);
        run_op("sltu",     4'd6, 32'hFFFF_FFFF, 32'd1,          1, 32'd0,         5'b01000);
        run_op("sra31",    4'd9, 32'h8000_0000, 32'd31,        32, 32'hFFFF_FFFF, 5'b00010);
        run_op("sll0",     4'd7, 32'h1234_5678, 32'd0,          1, 32'h1234_5678, 5'b00000);
        run_op("sll3_hib", 4'd7, 32'd1,         32'h0000_0023,  4, 32'd8,         5'b00000);
        run_op("srl4",     4'd8, 32'h8000_0000, 32'd4,          5, 32'h0800_0000, 5'b00000);
        run_op("illegal11",4'd11,32'h1234_5678, 32'd7,          1, 32'd0,         5'b01001);
`ifdef ALU_SEQ_MUL_EN
        run_op("mul_ovf",  4'd10,32'h0001_0000, 32'h0001_0000, 33, 32'd0,         5'b01100);
        run_op("mul_small",4'd10,32'd3,         32'd5,         33, 32'd15,        5'b00000);
`else
        run_op("op10_ill", 4'd10,32'd3,         32'd5,          1, 32'd0,         5'b01001);
`endif

        // Backpressure: result held while out_ready=0; a competing request waits for IDLE.
        @(negedge clk);
        in_valid = 1'b1; op = 4'd0; a = 32'd2; b = 32'd3;
        @(negedge clk);
        op = 4'd4; a = 32'h0000_00FF; b = 32'h0000_000F;
        for (int i = 0; i < 5; i++) begin
            chk("bp/hold", {result[27:0], out_valid, in_ready, zero, carry}, {28'd5, 1'b1, 1'b0, 1'b0, 1'b0});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp/released", {30'd0, out_valid, in_ready}, 32'b01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp/second", {result[27:0], 3'd0, out_valid}, {28'h00000F0, 3'd0, 1'b1});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during a long shift aborts it without producing a result.
        in_valid = 1'b1; op = 4'd7; a = 32'd1; b = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("rst_mid/busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/async", {result, 1'b0} == 33'd0 ? {31'd0, out_valid} : 32'hDEAD, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid/in_ready", {31'd0, in_ready}, 32'd1);
        repeat (15) @(negedge clk);
        chk("rst_mid/no_stale", {result[29:0], out_valid, in_ready}, {30'd0, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
